// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with wrap-bit pointers, threshold flags and sticky error flags
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  input  logic              flush,
  input  logic              clr_err,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              rd_acc, wr_acc, wr_err, rd_err;
  assign empty        = wr_ptr_q == rd_ptr_q;
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = count >= AF_LEVEL[AW:0];
  assign almost_empty = count <= AE_LEVEL[AW:0];
  assign data_out     = data_out_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  // a flush cycle neither moves data nor raises errors; a read frees the slot a full-FIFO write needs
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_acc = wr_en && (!full || rd_acc) && !flush;
  assign wr_err = wr_en && !wr_acc && !flush;
  assign rd_err = rd_en && !rd_acc && !flush;
  // next-state: pointers, registered read data, sticky errors (new event beats clr_err)
  always_comb begin
    wr_ptr_d    = flush ? '0 : wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = flush ? '0 : rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    data_out_d  = rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : data_out_q;
    overflow_d  = flush ? overflow_q : wr_err || (overflow_q && !clr_err);
    underflow_d = flush ? underflow_q : rd_err || (underflow_q && !clr_err);
  end
  // control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // storage is never reset; only accepted writes touch it
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: table vectors, directed corners and random traffic against a queue model
module tb_param_sync_fifo;
  localparam int DW = 8, DEPTH = 16, AF = 12, AE = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] data_in = '0, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int n_vec = 0, n_err = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit m_ovf, m_udf;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .flush(flush), .clr_err(clr_err), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  typedef struct {
    bit w, r, f, c;
    logic [7:0] d;
    int cnt;
    logic [7:0] dout;
    bit emp, ovf, udf;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic check_all();
    chk("count", int'(count), q.size());
    chk("data_out", int'(data_out), int'(m_dout));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("almost_full", int'(almost_full), int'(q.size() >= AF));
    chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_udf));
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f = 0, input bit c = 0);
    bit rok, wok;
    wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
    if (f) q.delete();
    else begin
      rok = r && q.size() > 0;
      wok = w && (q.size() < DEPTH || rok);
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
      m_ovf = (w && !wok) || (m_ovf && !c);
      m_udf = (r && !rok) || (m_udf && !c);
    end
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
  endtask

  initial begin
    vt[0]  = '{1, 0, 0, 0, 8'h11, 1, 8'h00, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 8'h22, 2, 8'h00, 0, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 8'h00, 1, 8'h11, 0, 0, 0};
    vt[3]  = '{1, 1, 0, 0, 8'h33, 1, 8'h22, 0, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 8'h00, 0, 8'h33, 1, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 8'h00, 0, 8'h33, 1, 0, 1};
    vt[6]  = '{1, 1, 0, 0, 8'h44, 1, 8'h33, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 1, 8'h00, 1, 8'h33, 0, 0, 0};
    vt[8]  = '{1, 0, 1, 0, 8'h55, 0, 8'h33, 1, 0, 0};
    vt[9]  = '{0, 1, 0, 0, 8'h00, 0, 8'h33, 1, 0, 1};
    vt[10] = '{1, 0, 0, 1, 8'h66, 1, 8'h33, 0, 0, 0};
    vt[11] = '{0, 1, 0, 0, 8'h00, 0, 8'h66, 1, 0, 0};
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].w, vt[i].d, vt[i].r, vt[i].f, vt[i].c);
      chk($sformatf("vec%0d.count", i), int'(count), vt[i].cnt);
      chk($sformatf("vec%0d.dout", i), int'(data_out), int'(vt[i].dout));
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(vt[i].emp));
      chk($sformatf("vec%0d.ovf", i), int'(overflow), int'(vt[i].ovf));
      chk($sformatf("vec%0d.udf", i), int'(underflow), int'(vt[i].udf));
    end
    // fill and drain in order
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    chk("fill.full", int'(full), 1);
    chk("fill.count", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1);
      chk("drain.dout", int'(data_out), i);
    end
    chk("drain.empty", int'(empty), 1);
    cyc(0, 0, 1);
    chk("underflow.set", int'(underflow), 1);
    chk("underflow.dout_hold", int'(data_out), 15);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0);
    cyc(1, 8'hAA, 0);
    chk("overflow.count", int'(count), 16);
    chk("overflow.set", int'(overflow), 1);
    cyc(0, 0, 0, 0, 1);
    chk("clr.ovf", int'(overflow), 0);
    chk("clr.udf", int'(underflow), 0);
    cyc(1, 8'h55, 1);
    chk("simfull.count", int'(count), 16);
    chk("simfull.full", int'(full), 1);
    chk("simfull.ovf", int'(overflow), 0);
    chk("simfull.dout", int'(data_out), 8'h80);
    cyc(1, 8'hEE, 0, 0, 1);
    chk("errprio.ovf", int'(overflow), 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("simfull.last", int'(data_out), 8'h55);
    cyc(1, 8'h5A, 1, 0, 1);
    chk("simempty.count", int'(count), 1);
    chk("simempty.udf", int'(underflow), 1);
    cyc(0, 0, 1, 0, 1);
    chk("simempty.dout", int'(data_out), 8'h5A);
    // thresholds
    for (int i = 0; i < 11; i++) cyc(1, 8'(i + 8'h20), 0);
    chk("af.at11", int'(almost_full), 0);
    cyc(1, 8'h2B, 0);
    chk("af.at12", int'(almost_full), 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1);
    chk("ae.at3", int'(almost_empty), 0);
    cyc(0, 0, 1);
    chk("ae.at2", int'(almost_empty), 1);
    chk("ae.count", int'(count), 2);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    // wrap: hold occupancy at 5 across several pointer wraps
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(8'hC5 + i), 1);
      chk("wrap.dout", int'(data_out), 8'hC0 + i);
    end
    chk("wrap.count", int'(count), 5);
    for (int i = 0; i < 2; i++) cyc(1, 8'(8'h70 + i), 0);
    cyc(0, 0, 0, 1);
    chk("flush.count", int'(count), 0);
    chk("flush.empty", int'(empty), 1);
    chk("flush.dout", int'(data_out), 8'hC0 + 39);
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h90 + i), 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 8'h99, 0);
    cyc(1, 8'h9A, 0);
    cyc(1, 8'h9B, 0);
    chk("prereset.count", int'(count), 9);
    #2;
    rst = 1;
    model_reset();
    #1;
    check_all();
    chk("reset.dout", int'(data_out), 0);
    @(negedge clk);
    rst = 0;
    cyc(1, 8'h77, 0);
    chk("postreset.count", int'(count), 1);
    cyc(0, 0, 1);
    chk("postreset.dout", int'(data_out), 8'h77);
    // random traffic
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) == 0, $urandom_range(0, 99) < 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
